// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MINI-MIPS multi-cycle controller and datapath:
// FSM states, opcode/funct values, mux select codes and the control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'd0;
    localparam logic [1:0] MEMTOREG_MDR    = 2'd1;
    localparam logic [1:0] MEMTOREG_PC     = 2'd2;

    localparam logic [1:0] ALUB_B       = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Where DECODE dispatches to; S_FETCH means the instruction is unsupported.
    function automatic state_t decode_target(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        state_t target;
        case (opcode)
            OP_RTYPE: target = (funct == FN_JR) ? S_JR : S_EXEC;
            OP_LW,
            OP_SW:    target = S_MEMADR;
            OP_BEQ:   target = S_BRANCH;
            OP_ADDI:  target = S_ADDIEX;
            OP_J:     target = S_JUMP;
            OP_JAL:   target = S_JAL;
            default:  target = S_FETCH;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MINI-MIPS control FSM: state register, next-state logic and a
// Moore output decode with memReady-qualified strobes for the handshake.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       IorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] regDst,
    output logic [1:0] memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       instrDone,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;
    state_t dispatch;
    ctrl_t  ctrl;

    // The branch decision on zero is made in the datapath through pcWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    assign dispatch = decode_target(opcode, funct);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (memReady) state_d = S_DECODE;
            S_DECODE: state_d = dispatch;
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (memReady) state_d = S_MEMWB;
            S_MEMWR:  if (memReady) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB,
            S_RWB,
            S_BRANCH,
            S_JUMP,
            S_ADDIWB,
            S_JAL,
            S_JR:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // NOTE: the reset here is synchronous, so it lives inside the clocked branch
    // and is not in the sensitivity list; sequential state uses <= only.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.i_or_d    = 1'b0;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = ALUB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    // IR and PC must load exactly once, on the completing cycle.
                    ctrl.ir_write  = memReady;
                    ctrl.pc_write  = memReady;
                end
                S_DECODE: begin
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = ALUB_IMM_SH2;
                    ctrl.alu_op    = ALUOP_ADD;
                    if (dispatch == S_FETCH) begin
                        ctrl.illegal    = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                end
                S_MEMADR,
                S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RT;
                    ctrl.mem_to_reg = MEMTOREG_MDR;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write  = 1'b1;
                    ctrl.i_or_d     = 1'b1;
                    ctrl.instr_done = memReady;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALUB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RD;
                    ctrl.mem_to_reg = MEMTOREG_ALUOUT;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = ALUB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    ctrl.instr_done    = 1'b1;
                end
                S_ADDIWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RT;
                    ctrl.mem_to_reg = MEMTOREG_ALUOUT;
                    ctrl.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                S_JAL: begin
                    // The link value is the PC itself, already advanced to PC+4 in FETCH.
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RA;
                    ctrl.mem_to_reg = MEMTOREG_PC;
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_JUMP;
                    ctrl.instr_done = 1'b1;
                end
                S_JR: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_source  = PCSRC_REG;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign pcWrite     = ctrl.pc_write;
    assign pcWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign memRead     = ctrl.mem_read;
    assign memWrite    = ctrl.mem_write;
    assign irWrite     = ctrl.ir_write;
    assign regDst      = ctrl.reg_dst;
    assign memToReg    = ctrl.mem_to_reg;
    assign regWrite    = ctrl.reg_write;
    assign aluSrcA     = ctrl.alu_src_a;
    assign aluSrcB     = ctrl.alu_src_b;
    assign aluOp       = ctrl.alu_op;
    assign pcSource    = ctrl.pc_source;
    assign instrDone   = ctrl.instr_done;
    assign illegal     = ctrl.illegal;
    assign state       = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM for the MINI-MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several cycles per instruction. It drives all datapath selects, including the 2-bit regDst that picks the register-file write address. Memory accesses use a ready handshake, so variable-latency memory stalls the FSM.

Parameters:
None. Opcodes and encodings are fixed in the shared package.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  6  IR[31:26]; stable from DECODE until instruction end
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
memReady  input  1  memory completes the current read/write this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if zero
IorD  output  1  0=PC, 1=ALUOut as memory address
memRead  output  1  memory read request
memWrite  output  1  memory write request
irWrite  output  1  IR load
regDst  output  2  0=rt, 1=rd, 2=$31
memToReg  output  2  0=ALUOut, 1=MDR, 2=PC
regWrite  output  1  register-file write enable
aluSrcA  output  1  0=PC, 1=A
aluSrcB  output  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
aluOp  output  2  0=add, 1=sub, 2=funct-decoded
pcSource  output  2  0=ALU, 1=ALUOut, 2=jump target, 3=A (jr)
instrDone  output  1  one-cycle pulse in the final cycle of each instruction
illegal  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current state, for debug

Behaviour:
- Reset: synchronous, active-low. An edge with rst_n=0 loads state=FETCH. While rst_n=0, every output except state is forced 0. The first cycle after release is FETCH.
- Outputs: Moore-decoded from state, except the handshake-qualified strobes noted below. Every unlisted output is 0 in every state.
- Supported instructions:
  - R-type: op 0x00; funct 0x08 = jr, all other funct values use R-type ALU.
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02, jal 0x03.
- States (encoding 0-13): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB, JAL, JR.
- FETCH:
  - memRead=1, IorD=0, aluSrcA=0, aluSrcB=1, aluOp=0, pcSource=0.
  - irWrite and pcWrite are asserted only while memReady=1.
  - Holds until memReady, then goes to DECODE.
- DECODE:
  - aluSrcA=0, aluSrcB=3, aluOp=0 (branch target into ALUOut).
  - Next state: lw/sw -> MEMADR; R-type (non-jr) -> EXEC; jr -> JR; beq -> BRANCH; addi -> ADDIEX; j -> JUMP; jal -> JAL.
  - Any other opcode -> FETCH with illegal=1 and instrDone=1.
- MEMADR: aluSrcA=1, aluSrcB=2, aluOp=0. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: memRead=1, IorD=1. Holds until memReady, then MEMWB.
- MEMWB: regWrite=1, regDst=0, memToReg=1, instrDone=1. Goes to FETCH.
- MEMWR: memWrite=1, IorD=1. Holds until memReady; instrDone=1 in the memReady cycle, then FETCH.
- EXEC: aluSrcA=1, aluSrcB=0, aluOp=2. Goes to RWB.
- RWB: regWrite=1, regDst=1, memToReg=0, instrDone=1. Goes to FETCH.
- BRANCH:
  - aluSrcA=1, aluSrcB=0, aluOp=1, pcWriteCond=1, pcSource=1, instrDone=1. Goes to FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=2, aluOp=0. Goes to ADDIWB.
- ADDIWB: regWrite=1, regDst=0, memToReg=0, instrDone=1. Goes to FETCH.
- JUMP: pcWrite=1, pcSource=2, instrDone=1. Goes to FETCH.
- JAL:
  - regWrite=1, regDst=2, memToReg=2, pcWrite=1, pcSource=2, instrDone=1. Goes to FETCH.
  - The PC source value is PC+4, already committed in FETCH.
- JR: pcWrite=1, pcSource=3, instrDone=1. Goes to FETCH.
- Handshake: memRead/memWrite stay asserted and stable across stall cycles. No strobe other than memRead/memWrite may repeat during a stall. memReady outside FETCH/MEMRD/MEMWR is ignored.
- Minimum latency per instruction, with memReady=1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j/jal/jr 3.
  - Each memory stall cycle adds 1.
- Reset mid-instruction: the FSM aborts; no regWrite/memWrite is asserted in the reset cycle.
- Invalid state encodings (14, 15) return to FETCH on the next edge.

Decomposition:
- Shared package mips_ctrl_pkg contains:
  - state encoding constants;
  - opcode/funct constants;
  - regDst, memToReg, aluSrcB, aluOp and pcSource code constants, also used by the write-address mux and the datapath.
- No sub-module: a single FSM with a next-state block and an output-decode block.

Test Plan:
- Reset then add: rst_n=0 for 2 cycles, then op=0x00, funct=0x20, memReady=1. Required: states 0,1,6,7; regWrite=1, regDst=1 only in cycle 4; instrDone at cycle 4.
- lw with 3-cycle read stall: op=0x23, memReady low for 3 cycles in MEMRD. Required: memRead held 4 cycles; then MEMWB with regDst=0, memToReg=1; total 8 cycles.
- jal: op=0x03. Required: JAL state with regDst=2, memToReg=2, pcSource=2, pcWrite=1; 3 cycles total.
- beq: op=0x04, zero=1, then zero=0. Required: pcWriteCond=1, pcSource=1 in BRANCH both times; regWrite never asserted.
- Illegal opcode 0x3F: required illegal=1 and instrDone=1 in DECODE, then FETCH; no regWrite/memWrite.
- Reset asserted in MEMWR with memReady=0: required memWrite=0 during the reset cycle; state=0 after the edge.
